// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, result struct and width helper for the log2 encoder.
package decoder_pkg;
    localparam int DEC_IN_W = 8;
    // Index field is sized for the widest supported input; users slice to their OUT_W.
    localparam int DEC_IDX_W = 16;

    function automatic int dec_out_w(input int in_w);
        return (in_w < 2) ? 1 : $clog2(in_w);
    endfunction

    localparam int DEC_OUT_W = dec_out_w(DEC_IN_W);

    typedef struct packed {
        logic [DEC_IDX_W-1:0] index;
        logic                 zero;
        logic                 multi;
    } dec_result_t;
endpackage

// File: rtl/decoder_core.sv
// decoder_core: combinational MSB-priority scan producing index, zero and multi flags.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_W = DEC_IN_W
) (
    input  logic [IN_W-1:0] in_i,
    output dec_result_t     res_o
);
    always_comb begin
        res_o = '0;
        for (int i = 0; i < IN_W; i++) res_o.index = in_i[i] ? DEC_IDX_W'(i) : res_o.index;
        res_o.zero  = in_i == '0;
        res_o.multi = (in_i & (in_i - IN_W'(1))) != '0;
    end
endmodule

// File: rtl/decoder.sv
// decoder: one-hot to binary index with a combinational path and a one-cycle registered copy.
module decoder
    import decoder_pkg::*;
#(
    parameter  int IN_W  = DEC_IN_W,
    localparam int OUT_W = dec_out_w(IN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic             zero,
    output logic             multi,
    output logic [OUT_W-1:0] out_q,
    output logic             zero_q,
    output logic             multi_q,
    output logic             out_valid
);
    dec_result_t res, res_d, res_q;
    logic        vld_d, vld_q;
    logic        unused_hi;

    decoder_core #(.IN_W(IN_W)) u_core (
        .in_i  (in),
        .res_o (res)
    );

    // Only the low OUT_W index bits are meaningful; the rest are always zero.
    always_comb begin
        res_d       = rst ? '0 : (in_valid ? res : res_q);
        res_d.index = {{(DEC_IDX_W-OUT_W){1'b0}}, res_d.index[OUT_W-1:0]};
        vld_d       = !rst && in_valid;
    end

    always_ff @(posedge clk) begin
        res_q <= res_d;
        vld_q <= vld_d;
    end

    assign unused_hi = ^{res.index[DEC_IDX_W-1:OUT_W], res_q.index[DEC_IDX_W-1:OUT_W]};
    assign out       = res.index[OUT_W-1:0];
    assign zero      = res.zero;
    assign multi     = res.multi;
    assign out_q     = res_q.index[OUT_W-1:0];
    assign zero_q    = res_q.zero;
    assign multi_q   = res_q.multi;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed and exhaustive checks of the combinational and registered decoder paths.
module tb_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in = '0;
    logic       in_valid = 1'b0;
    logic [2:0] out, out_q;
    logic       zero, multi, zero_q, multi_q, out_valid;
    int         n_chk = 0;
    int         n_pass = 0;

    decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .zero      (zero),
        .multi     (multi),
        .out_q     (out_q),
        .zero_q    (zero_q),
        .multi_q   (multi_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input logic [7:0] v, input logic vld, input logic r);
        @(negedge clk);
        in = v;
        in_valid = vld;
        rst = r;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] e_idx;
        logic       e_zero, e_multi;
        drive(8'h00, 1'b1, 1'b1);
        edge_wait();
        edge_wait();
        chk("rst out_q", 32'(out_q), 0);
        chk("rst zero_q", 32'(zero_q), 0);
        chk("rst multi_q", 32'(multi_q), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) begin
            drive(8'(1 << i), 1'b0, 1'b0);
            chk("walk out", 32'(out), 32'(i));
            chk("walk zero", 32'(zero), 0);
            chk("walk multi", 32'(multi), 0);
        end
        drive(8'h00, 1'b1, 1'b0);
        chk("zero out", 32'(out), 0);
        chk("zero zero", 32'(zero), 1);
        chk("zero multi", 32'(multi), 0);
        edge_wait();
        chk("zero out_q", 32'(out_q), 0);
        chk("zero zero_q", 32'(zero_q), 1);
        chk("zero out_valid", 32'(out_valid), 1);
        drive(8'b0010_0110, 1'b0, 1'b0);
        chk("multi26 out", 32'(out), 5);
        chk("multi26 multi", 32'(multi), 1);
        chk("multi26 zero", 32'(zero), 0);
        drive(8'hFF, 1'b0, 1'b0);
        chk("multiFF out", 32'(out), 7);
        chk("multiFF multi", 32'(multi), 1);
        edge_wait();
        chk("hold zero_q", 32'(zero_q), 1);
        chk("idle out_valid", 32'(out_valid), 0);
        drive(8'd4, 1'b1, 1'b0);
        edge_wait();
        chk("pipe0 out_q", 32'(out_q), 2);
        chk("pipe0 out_valid", 32'(out_valid), 1);
        drive(8'd64, 1'b1, 1'b0);
        edge_wait();
        chk("pipe1 out_q", 32'(out_q), 6);
        chk("pipe1 out_valid", 32'(out_valid), 1);
        drive(8'd1, 1'b1, 1'b0);
        edge_wait();
        chk("pipe2 out_q", 32'(out_q), 0);
        chk("pipe2 out_valid", 32'(out_valid), 1);
        drive(8'd8, 1'b0, 1'b0);
        edge_wait();
        chk("pipe hold out_q", 32'(out_q), 0);
        chk("pipe end out_valid", 32'(out_valid), 0);
        drive(8'd32, 1'b1, 1'b0);
        edge_wait();
        chk("pre-rst out_q", 32'(out_q), 5);
        drive(8'd128, 1'b1, 1'b1);
        chk("rst comb out", 32'(out), 7);
        edge_wait();
        chk("midrst out_q", 32'(out_q), 0);
        chk("midrst out_valid", 32'(out_valid), 0);
        drive(8'd16, 1'b1, 1'b0);
        edge_wait();
        chk("postrst out_q", 32'(out_q), 4);
        chk("postrst out_valid", 32'(out_valid), 1);
        for (int v = 0; v < 256; v++) begin
            e_idx = '0;
            for (int b = 0; b < 8; b++) if (v[b]) e_idx = 3'(b);
            e_zero = v == 0;
            e_multi = $countones(v) > 1;
            drive(8'(v), 1'b1, 1'b0);
            chk("exh out", 32'(out), 32'(e_idx));
            chk("exh zero", 32'(zero), 32'(e_zero));
            chk("exh multi", 32'(multi), 32'(e_multi));
            edge_wait();
            chk("exh out_q", 32'(out_q), 32'(e_idx));
            chk("exh zero_q", 32'(zero_q), 32'(e_zero));
            chk("exh multi_q", 32'(multi_q), 32'(e_multi));
            chk("exh out_valid", 32'(out_valid), 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Log2 encoder: converts a one-hot input word into the binary index of its set bit (8 -> 3 bits by default).
- Combinational `out` path for immediate use; a one-cycle registered copy with status flags for pipelined consumers.
- Sits between one-hot select/grant logic and index-consuming datapaths.

Parameters:
- IN_W, 8, input width in bits; must be >= 2.
- OUT_W, $clog2(IN_W), output index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  IN_W  one-hot input word.
- in_valid  input  1  qualifies `in` for the registered path.
- out  output  OUT_W  combinational log2 of `in`.
- zero  output  1  combinational; high when in == 0.
- multi  output  1  combinational; high when more than one bit of `in` is set.
- out_q  output  OUT_W  registered copy of `out`.
- zero_q  output  1  registered copy of `zero`.
- multi_q  output  1  registered copy of `multi`.
- out_valid  output  1  high for one cycle after an accepted in_valid.

Behaviour:
- Combinational path: no clock dependency; settles within the same delta/cycle as `in`.
  - out = index of the highest set bit of `in` (priority toward MSB).
  - For a one-hot input, out = log2(in): 1->0, 2->1, 4->2, 8->3, 16->4, 32->5, 64->6, 128->7.
  - in == 0: out = 0, zero = 1, multi = 0.
  - Multiple bits set: out = index of the MSB set, multi = 1, zero = 0.
  - zero and multi are never both 1.
- Registered path: one register stage, latency 1 cycle.
  - On a rising clk with in_valid = 1: out_q, zero_q and multi_q capture out, zero and multi; out_valid <= 1.
  - With in_valid = 0: out_q, zero_q and multi_q hold their values; out_valid <= 0.
  - No backpressure; every valid input produces exactly one out_valid pulse.
  - Back-to-back valid inputs give back-to-back results, one per cycle.
- Reset: synchronous, active-high.
  - While rst = 1 at a clock edge: out_q = 0, zero_q = 0, multi_q = 0, out_valid = 0.
  - rst takes priority over in_valid.
  - An in_valid coincident with rst is dropped and produces no out_valid.
  - The combinational outputs are unaffected by rst.
- Width rules: out_q is zero-extended in no case; it is exactly OUT_W bits. IN_W that is not a power of two is legal; indices above IN_W-1 never occur.
- No X propagation from an all-zero input; all outputs are fully defined for all 2^IN_W inputs.

Decomposition:
- Shared package decoder_pkg holds:
  - default width constant DEC_IN_W = 8;
  - function clog2-based DEC_OUT_W;
  - a packed struct dec_result_t {index, zero, multi} used for both the comb and registered paths.
- One natural sub-module: decoder_core.
  - Purely combinational: a priority scan from MSB to LSB producing dec_result_t.
  - The multi flag comes from a popcount > 1 or an equivalent (in & (in-1)) != 0 test.
- Top-level decoder instantiates decoder_core and adds the output register and valid pipeline.

Test Plan:
- Walk one-hot, combinational: in = 1,2,4,8,16,32,64,128 -> out = 0..7, zero = 0, multi = 0 each step.
- Zero input: in = 0 -> out = 0, zero = 1, multi = 0.
  - Registered path with in_valid = 1 -> next cycle out_q = 0, zero_q = 1, out_valid = 1.
- Multi-hot: in = 8'b0010_0110 -> out = 5, multi = 1, zero = 0.
  - in = 8'hFF -> out = 7, multi = 1.
- Pipeline: in_valid high for 3 cycles with in = 4, 64, 1 -> out_q = 2, 6, 0 on the following 3 cycles, with out_valid high for exactly 3 cycles.
  - Then in_valid = 0 -> out_q holds 0 and out_valid = 0.
- Reset mid-stream: assert rst while in_valid = 1, in = 128 -> after the edge out_q = 0, out_valid = 0.
  - After rst deasserts with in = 16, in_valid = 1 -> out_q = 4 one cycle later.
- Exhaustive: all 256 input values compared against a reference model (MSB index, zero, popcount > 1) on both the comb and registered outputs.
